// File: rtl/replicate_sequencer.sv
// Ready/valid sequencer that builds {N{in_data}}, zero-extended to W*MAX_N bits.
// It appends one copy of the accepted element per clock by shift-and-OR.
module replicate_sequencer #(
    parameter int W     = 8,
    parameter int MAX_N = 4,
    parameter int CW    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_data,
    input  logic [CW-1:0]        in_count,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W*MAX_N-1:0]   out_data,
    output logic [CW-1:0]        out_count,
    output logic                 err
);

    localparam int              AW      = W * MAX_N;
    localparam logic [CW-1:0]   MAX_N_C = CW'(MAX_N);

    typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

    state_t          state;
    logic [AW-1:0]   acc;
    logic [CW-1:0]   rem;
    logic [W-1:0]    data_r;
    logic [CW-1:0]   n_eff;

    function automatic logic [CW-1:0] clamp_count(input logic [CW-1:0] c);
        return (c > MAX_N_C) ? MAX_N_C : c;
    endfunction

    always_comb n_eff = clamp_count(in_count);

    // Handshake flags decode the state directly, so they can never both be high.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);
    assign out_data  = acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            rem       <= '0;
            data_r    <= '0;
            out_count <= '0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_r    <= in_data;
                        rem       <= n_eff;
                        acc       <= '0;
                        out_count <= n_eff;
                        err       <= (in_count > MAX_N_C);
                        state     <= (n_eff != '0) ? FILL : HOLD;
                    end
                end
                FILL: begin
                    acc <= (acc << W) | AW'(data_r);
                    rem <= rem - 1'b1;
                    if (rem == CW'(1)) state <= HOLD;
                end
                HOLD: begin
                    // acc is left untouched on retirement; the next accept clears it.
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_replicate_sequencer.sv
// Bench for replicate_sequencer: directed vector table, reset/backpressure
// sequences and randomized jobs against a replication reference model.
module tb_replicate_sequencer;

    localparam int W     = 8;
    localparam int MAX_N = 4;
    localparam int CW    = 3;
    localparam int AW    = W * MAX_N;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic [CW-1:0]  in_count;
    logic           out_valid;
    logic           out_ready;
    logic [AW-1:0]  out_data;
    logic [CW-1:0]  out_count;
    logic           err;

    int passed = 0;
    int total  = 0;

    replicate_sequencer #(.W(W), .MAX_N(MAX_N), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_count(in_count),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_count(out_count),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  data;
        logic [CW-1:0] count;
        int            stall;
        logic [AW-1:0] exp_data;
        logic [CW-1:0] exp_count;
        logic          exp_err;
    } vec_t;

    vec_t vecs[7];

    // Reference: place n_eff copies of d at the low end with plain arithmetic.
    function automatic logic [AW-1:0] model_data(input logic [W-1:0] d, input int n);
        logic [AW-1:0] r;
        int neff;
        neff = (n > MAX_N) ? MAX_N : n;
        r = '0;
        for (int i = 0; i < neff; i++) r = r | (AW'(d) << (W * i));
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        else
            passed++;
    endtask

    task automatic run_job(input logic [W-1:0] d, input logic [CW-1:0] c, input int stall,
                           input logic [AW-1:0] ed, input logic [CW-1:0] ec,
                           input logic ee, input string tag);
        int lat;
        logic fill_ok, err_extra, hold_ok;
        logic [AW-1:0] held;
        @(negedge clk);
        check({tag, " idle_ready"}, 64'(in_ready), 64'd1);
        in_data = d; in_count = c; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_count = CW'($urandom);
        @(negedge clk);
        check({tag, " err"}, 64'(err), 64'(ee));
        lat = 0; fill_ok = 1'b1; err_extra = 1'b0;
        while (!out_valid && lat < 20) begin
            if (in_ready) fill_ok = 1'b0;
            @(negedge clk);
            lat++;
            if (err) err_extra = 1'b1;
        end
        check({tag, " latency"}, 64'(lat), 64'(ec));
        check({tag, " fill_ready_err"}, {62'd0, fill_ok, err_extra}, 64'd2);
        check({tag, " data"}, 64'(out_data), 64'(ed));
        check({tag, " count"}, 64'(out_count), 64'(ec));
        held = out_data;
        hold_ok = out_valid && !in_ready;
        repeat (stall) begin
            @(negedge clk);
            if (!out_valid || in_ready || out_data !== held || out_count !== ec) hold_ok = 1'b0;
        end
        check({tag, " hold_stable"}, 64'(hold_ok), 64'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check({tag, " retire"}, {in_ready, out_valid, out_data}, {1'b1, 1'b0, ed});
    endtask

    initial begin
        vecs[0] = '{8'hA5, 3'd4, 0, 32'hA5A5A5A5, 3'd4, 1'b0};
        vecs[1] = '{8'h3C, 3'd1, 0, 32'h0000003C, 3'd1, 1'b0};
        vecs[2] = '{8'h3C, 3'd0, 0, 32'h00000000, 3'd0, 1'b0};
        vecs[3] = '{8'h81, 3'd6, 0, 32'h81818181, 3'd4, 1'b1};
        vecs[4] = '{8'hFF, 3'd2, 3, 32'h0000FFFF, 3'd2, 1'b0};
        vecs[5] = '{8'h5A, 3'd3, 1, 32'h005A5A5A, 3'd3, 1'b0};
        vecs[6] = '{8'h07, 3'd7, 2, 32'h07070707, 3'd4, 1'b1};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_count = '0; out_ready = 1'b0;
        #3;
        check("reset_during", {in_ready, out_valid, err, 3'(out_count), out_data},
              {1'b1, 1'b0, 1'b0, 3'd0, 32'd0});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_after", {in_ready, out_valid, err, 3'(out_count), out_data},
              {1'b1, 1'b0, 1'b0, 3'd0, 32'd0});

        for (int i = 0; i < 7; i++)
            run_job(vecs[i].data, vecs[i].count, vecs[i].stall, vecs[i].exp_data,
                    vecs[i].exp_count, vecs[i].exp_err, $sformatf("vec%0d", i));

        // Reset asserted between the second and third FILL edges.
        @(negedge clk);
        in_data = 8'hA5; in_count = 3'd4; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 check("midfill_partial", 64'(out_data), 64'h0000A5A5);
        #1 rst = 1'b1;
        #1;
        check("midfill_reset", {in_ready, out_valid, err, 3'(out_count), out_data},
              {1'b1, 1'b0, 1'b0, 3'd0, 32'd0});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        run_job(8'h12, 3'd3, 0, 32'h00121212, 3'd3, 1'b0, "post_reset");

        for (int j = 0; j < 40; j++) begin
            logic [W-1:0]  rd;
            logic [CW-1:0] rc;
            int            rs;
            rd = W'($urandom);
            rc = CW'($urandom_range(0, 7));
            rs = $urandom_range(0, 2);
            run_job(rd, rc, rs, model_data(rd, int'(rc)),
                    (int'(rc) > MAX_N) ? CW'(MAX_N) : rc,
                    (int'(rc) > MAX_N), $sformatf("rand%0d", j));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/replicate_sequencer.md
# replicate_sequencer

Multi-cycle sequencer for the replication datapath: it accepts an element and a repeat count, then builds the zero-extended replicated word `{N{in_data}}` one copy per clock by shift-and-OR. It sits between a requester that issues replication jobs and any consumer of the replicated word. A ready/valid handshake is used on both sides. One job is in flight at a time.

## Interface
- `W`, default 8: element width in bits.
- `MAX_N`, default 4: maximum replication count; output width is `W*MAX_N`.
- `CW`, default 3: count width; `MAX_N < 2**CW` is required.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  a job is offered.
- `in_ready`  out  1  the sequencer can accept a job; high exactly in IDLE.
- `in_data`  in  W  element to replicate; sampled on accept.
- `in_count`  in  CW  replication count N; 0 is legal.
- `out_valid`  out  1  `out_data` holds a finished result; high exactly in HOLD.
- `out_ready`  in  1  the consumer takes the result.
- `out_data`  out  W*MAX_N  replicated word, zero-extended at the MSB end.
- `out_count`  out  CW  effective (clamped) count of the current result.
- `err`  out  1  one-cycle pulse when the accepted `in_count` exceeded `MAX_N`.

## Operation
- States are IDLE, FILL and HOLD. Reset enters IDLE.
- Accept happens at a rising edge where `in_valid && in_ready`.
- On accept:
  - Register `data_r <= in_data`.
  - Set `n_eff = min(in_count, MAX_N)`.
  - Set `rem <= n_eff`, `acc <= 0` and `out_count <= n_eff`.
  - Set `err <= (in_count > MAX_N)`.
  - Go to FILL if `n_eff > 0`, otherwise go to HOLD.
- FILL, every edge:
  - `acc <= (acc << W) | data_r`, truncated to `W*MAX_N` bits.
  - `rem <= rem - 1`.
  - When `rem == 1`, go to HOLD.
- HOLD:
  - `out_valid = 1` and `out_data = acc`, both stable until the handshake.
  - On an edge with `out_ready` high, go to IDLE; `acc` and `out_data` keep their value.
- `in_data`/`in_count` changes outside the accept edge have no effect.
- `out_ready` is ignored outside HOLD.
- `err` is high for exactly the one cycle following the accept edge; otherwise 0.
- The result equals `{ (MAX_N-n_eff)*W'b0, {n_eff{data_r}} }`.
- For `N=1`, `out_data == {0..., data_r}`. For `N=0`, `out_data == 0`.
- There is no accept in HOLD or FILL, so a new job cannot be accepted on the same edge as output retirement.

## Timing
- Reset values, while `rst` is high and after its release:
  - State IDLE, so `in_ready = 1`.
  - `out_valid = 0`, `out_data = 0`, `out_count = 0`, `err = 0`.
  - Internal `acc = 0`, `rem = 0`, `data_r = 0`.
- Reset asserted mid-FILL or mid-HOLD aborts the job immediately (asynchronously). No partial result is presented.
- Latency: with accept at edge t, `out_valid` rises after edge t+N_eff.
  - For `N_eff=0`, `out_valid` rises after edge t (next cycle).
  - For `MAX_N=4` and N=4, `out_valid` is first seen after edge t+4.
- Next job acceptance:
  - `in_ready` returns high in the cycle after the retiring edge.
  - Minimum job period is `N_eff + 2` cycles with `out_ready` tied high.
- `in_ready` and `out_valid` are pure functions of state. They are never both high.

## Test plan
- Job `in_data=8'hA5`, `in_count=4`, `out_ready=1`: `in_ready` low for 5 cycles; `out_valid` after edge t+4 with `out_data=32'hA5A5A5A5`, `out_count=4`, `err=0`.
- `in_data=8'h3C` with N=1, then N=0:
  - N=1 gives `32'h0000003C` one cycle after accept.
  - N=0 gives `out_data=0` and `out_count=0` in the cycle after accept.
- `in_data=8'h81`, `in_count=6` (above `MAX_N`): `err` high for exactly one cycle; result `32'h81818181`, `out_count=4`.
- Backpressure: N=2, `in_data=8'hFF`, `out_ready` low for 3 HOLD cycles. `out_data=32'h0000FFFF` stays stable with `out_valid` held high and `in_ready` low; retires on the first edge with `out_ready` high.
- Input change after accept: `in_data` changes to `8'h00` during FILL; the result still uses the accepted value.
- Reset mid-FILL: N=4, assert `rst` between edges t+2 and t+3. All outputs are 0 immediately and `in_ready=1`. A fresh job after release (`8'h12`, N=3) yields `32'h00121212`.
